// File: rtl/spi_flash_icache.sv
// Direct-mapped, one-word-per-line read-only instruction cache placed between
// the core fetch port and the SPI flash reader. Lines are filled only on a miss
// and invalidated only by flush_i or reset.
//
// Handshake (core side and memory side alike): the requester raises req with a
// stable address and holds both until the responder pulses rvalid for exactly
// one cycle with the data. Dropping req before rvalid aborts the transaction
// and no rvalid follows.
module spi_flash_icache #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned FADDR_WIDTH = 24
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            instr_req_i,
    input  logic [XLEN-1:0] instr_addr_i,
    output logic            instr_rvalid_o,
    output logic [XLEN-1:0] instr_rdata_o,
    input  logic            flush_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [31:0]     hit_cnt_o,
    output logic [31:0]     miss_cnt_o
);

    localparam int unsigned LINES = 1 << INDEX_WIDTH;
    localparam int unsigned TAG_W = FADDR_WIDTH - INDEX_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2
    } state_e;

    state_e                 state_q;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic [TAG_W-1:0]       tag_q;
    logic [LINES-1:0]       valid_q;
    logic                   instr_rvalid_q;
    logic [XLEN-1:0]        instr_rdata_q;
    logic [31:0]            hit_cnt_q;
    logic [31:0]            miss_cnt_q;
    logic [31:0]            hit_cnt_d;
    logic [31:0]            miss_cnt_d;

    // Tag and data storage carry no reset; the valid bits alone gate their use.
    logic [TAG_W-1:0]       tag_arr  [LINES];
    logic [XLEN-1:0]        data_arr [LINES];

    logic                   lookup_hit;
    logic                   fill_we;

    // Byte-offset bits and the address bits above the flash window play no part.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[XLEN-1:FADDR_WIDTH], instr_addr_i[1:0]};

    // Arrays are read with the index captured in IDLE, so the lookup sees the
    // valid bits as they stood before any flush landing on the same edge.
    assign lookup_hit = valid_q[idx_q] && (tag_arr[idx_q] == tag_q);
    assign fill_we    = (state_q == MISS) && mem_rvalid_i;

    assign hit_cnt_d  = (hit_cnt_q  == 32'hFFFF_FFFF) ? hit_cnt_q  : hit_cnt_q  + 32'd1;
    assign miss_cnt_d = (miss_cnt_q == 32'hFFFF_FFFF) ? miss_cnt_q : miss_cnt_q + 32'd1;

    // Memory request is combinational so it falls in the very cycle rvalid
    // arrives (or req is withdrawn), keeping the flash reader from restarting.
    assign mem_req_o  = (state_q == MISS) && instr_req_i && !mem_rvalid_i;
    assign mem_addr_o = XLEN'({tag_q, idx_q, 2'b00});

    assign instr_rvalid_o = instr_rvalid_q;
    assign instr_rdata_o  = instr_rdata_q;
    assign hit_cnt_o      = hit_cnt_q;
    assign miss_cnt_o     = miss_cnt_q;

    // Control FSM with registered core response, valid bits and counters.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            tag_q          <= '0;
            valid_q        <= '0;
            instr_rvalid_q <= 1'b0;
            instr_rdata_q  <= '0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
        end else begin
            instr_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_req_i) begin
                        idx_q   <= instr_addr_i[INDEX_WIDTH+1:2];
                        tag_q   <= instr_addr_i[FADDR_WIDTH-1:INDEX_WIDTH+2];
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!instr_req_i) begin
                        state_q <= IDLE;
                    end else if (lookup_hit) begin
                        instr_rvalid_q <= 1'b1;
                        instr_rdata_q  <= data_arr[idx_q];
                        hit_cnt_q      <= hit_cnt_d;
                        state_q        <= IDLE;
                    end else begin
                        state_q <= MISS;
                    end
                end
                MISS: begin
                    if (mem_rvalid_i) begin
                        valid_q[idx_q] <= 1'b1;
                        miss_cnt_q     <= miss_cnt_d;
                        state_q        <= IDLE;
                        if (instr_req_i) begin
                            instr_rvalid_q <= 1'b1;
                            instr_rdata_q  <= mem_rdata_i;
                        end
                    end else if (!instr_req_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Placed last so a flush overrides a fill landing on the same edge.
            if (flush_i) begin
                valid_q <= '0;
            end
        end
    end

    // Fill write of tag and data when the flash reader returns the word.
    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            tag_arr[idx_q]  <= tag_q;
            data_arr[idx_q] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_spi_flash_icache.sv
// Directed plus randomised fetch sequence for spi_flash_icache with a small
// reference model of the line store and a queue of expected core read data.
module tb_spi_flash_icache;

    logic        clk_i;
    logic        arstn_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    spi_flash_icache dut (
        .clk_i          (clk_i),
        .arstn_i        (arstn_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .flush_i        (flush_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .hit_cnt_o      (hit_cnt_o),
        .miss_cnt_o     (miss_cnt_o)
    );

    // Clock: 10 time-unit period; inputs change on the falling edge.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Reference model of the cache contents and expected counters.
    logic [63:0] mvalid;
    logic [15:0] mtag [64];
    logic [31:0] mdat [64];
    logic [31:0] exp_q [$];
    int          exp_hits;
    int          exp_misses;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        mvalid = '0;
    endtask

    // One core fetch, called on a falling edge. Acts as the flash reader too.
    // abort_at: withdraw req on that cycle of mem_req (0 = never).
    // flush_mode: 0 none, 1 flush with the fill, 2 flush during LOOKUP.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] mdata,
                         input int lat, input int abort_at, input int flush_mode);
        logic [5:0]  idx;
        logic [15:0] tg;
        logic [31:0] exp_maddr;
        logic [31:0] e;
        bit          exp_hit;
        bit          done;
        bit          filled;
        bit          late_rvalid;
        int          n;
        int          req_cycles;
        idx       = addr[7:2];
        tg        = addr[23:8];
        exp_maddr = {8'h00, addr[23:2], 2'b00};
        exp_hit   = mvalid[idx] && (mtag[idx] == tg);
        if (abort_at == 0) exp_q.push_back(exp_hit ? mdat[idx] : mdata);
        instr_addr_i = addr;
        instr_req_i  = 1'b1;
        n = 0; req_cycles = 0; done = 0; filled = 0;
        while (!done && n < 400) begin
            @(negedge clk_i);
            n++;
            flush_i = 1'b0;
            if (mem_rvalid_i) begin
                mem_rvalid_i = 1'b0;
                filled = 1;
                #1;
                check("mem_req_after_fill", {31'b0, mem_req_o}, 32'd0);
            end
            if (flush_mode == 2 && n == 1) flush_i = 1'b1;
            if (instr_rvalid_o) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_unexpected", {31'b0, instr_rvalid_o}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", instr_rdata_o, e);
                end
                if (exp_hit) check("hit_latency", n, 32'd2);
                instr_req_i = 1'b0;
                done = 1;
            end else if (mem_req_o) begin
                req_cycles++;
                if (req_cycles == 1) check("mem_addr", mem_addr_o, exp_maddr);
                if (abort_at != 0 && req_cycles == abort_at) begin
                    instr_req_i = 1'b0;
                    #1;
                    check("mem_req_abort", {31'b0, mem_req_o}, 32'd0);
                    done = 1;
                end else if (req_cycles == lat) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mdata;
                    if (flush_mode == 1) flush_i = 1'b1;
                    #1;
                    check("mem_req_drop", {31'b0, mem_req_o}, 32'd0);
                end
            end
        end
        check("fetch_timeout", {31'b0, done}, 32'd1);
        check("mem_req_cycles", req_cycles, exp_hit ? 32'd0 : (abort_at != 0 ? abort_at : lat));
        if (abort_at != 0) begin
            late_rvalid = 0;
            repeat (4) begin
                @(negedge clk_i);
                if (instr_rvalid_o || mem_req_o) late_rvalid = 1;
            end
            check("abort_quiet", {31'b0, late_rvalid}, 32'd0);
        end
        if (!exp_hit && filled) begin
            exp_misses++;
            if (flush_mode == 1) begin
                mvalid = '0;
            end else begin
                mvalid[idx] = 1'b1;
                mtag[idx]   = tg;
                mdat[idx]   = mdata;
            end
        end
        if (exp_hit && done) exp_hits++;
        if (flush_mode == 2) mvalid = '0;
        check("hit_cnt", hit_cnt_o, exp_hits);
        check("miss_cnt", miss_cnt_o, exp_misses);
    endtask

    // Directed sequence followed by random fetches and a reset during a miss.
    initial begin
        int          n;
        logic [31:0] a;
        arstn_i = 1'b0; instr_req_i = 1'b0; instr_addr_i = '0; flush_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        mvalid = '0; exp_hits = 0; exp_misses = 0; n_checks = 0; n_fail = 0;
        repeat (3) @(negedge clk_i);
        check("rst_rvalid", {31'b0, instr_rvalid_o}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_rdata", instr_rdata_o, 32'd0);
        check("rst_hit_cnt", hit_cnt_o, 32'd0);
        check("rst_miss_cnt", miss_cnt_o, 32'd0);
        arstn_i = 1'b1;
        @(negedge clk_i);

        // Cold miss, then hits including an alias through the ignored upper bits.
        fetch(32'h0000_0100, 32'hDEAD_BEEF, 20, 0, 0);
        fetch(32'h0000_0100, 32'h0BAD_0BAD, 20, 0, 0);
        fetch(32'hFF00_0101, 32'h0BAD_0BAD, 20, 0, 0);

        // Eviction between two tags sharing index 0.
        do_flush();
        fetch(32'h0000_0100, 32'h1111_1111, 3, 0, 0);
        fetch(32'h0000_0200, 32'h2222_2222, 4, 0, 0);
        fetch(32'h0000_0100, 32'h3333_3333, 5, 0, 0);

        // Abort five cycles into a miss leaves the line unfilled.
        fetch(32'h0000_0180, 32'h4444_4444, 20, 5, 0);
        fetch(32'h0000_0180, 32'h5555_5555, 6, 0, 0);

        // Flush coinciding with a fill: data returned, line left invalid.
        fetch(32'h0000_0040, 32'h6666_6666, 7, 0, 1);
        fetch(32'h0000_0040, 32'h7777_7777, 3, 0, 0);

        // Flush during LOOKUP still hits on the old valid bits.
        fetch(32'h0000_0040, 32'h0BAD_0BAD, 3, 0, 2);
        fetch(32'h0000_0040, 32'h8888_8888, 2, 0, 0);

        // Random mix over a few indices and tags, issued back-to-back.
        for (int i = 0; i < 24; i++) begin
            a = {8'($urandom_range(0, 255)), 16'($urandom_range(1, 3)),
                 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            fetch(a, $urandom, $urandom_range(1, 8), 0, 0);
        end
        @(negedge clk_i);
        check("rvalid_one_cycle", {31'b0, instr_rvalid_o}, 32'd0);

        // Reset while a miss is outstanding.
        instr_addr_i = 32'h0000_0300;
        instr_req_i  = 1'b1;
        n = 0;
        while (!mem_req_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("pre_rst_mem_req", {31'b0, mem_req_o}, 32'd1);
        arstn_i = 1'b0;
        #1;
        check("rst_mid_miss_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_mid_miss_hits", hit_cnt_o, 32'd0);
        check("rst_mid_miss_misses", miss_cnt_o, 32'd0);
        instr_req_i = 1'b0;
        @(negedge clk_i);
        arstn_i = 1'b1;
        mvalid = '0; exp_hits = 0; exp_misses = 0;
        @(negedge clk_i);
        fetch(32'h0000_0300, 32'h9999_9999, 3, 0, 0);
        fetch(32'h0000_0300, 32'h0BAD_0BAD, 3, 0, 0);

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
